layer_scheduler: RTL and testbench
==================================

// Module: layer_scheduler
// PURPOSE
//  Time-multiplexes one 1024-input saturating synapse accumulator across NUM_NEURONS neurons per timestep.
//  Latches the input spike vector, walks weight-memory rows (one row per neuron) and captures the 8-bit count.
//  Performs a leaky integrate-and-fire update on a per-neuron membrane register file.
//  Emits the layer's output spike vector with a start/busy/done handshake.
// PARAMETERS
//  NUM_NEURONS  32  neurons (weight rows) per layer, >=2
//  MEM_LATENCY  1   cycles from w_rd_en to valid acc_u_in, >=1
//  V_W          12  membrane potential width (unsigned)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           synchronous, active-high reset
//  start         in   1           begin a timestep; accepted only in IDLE
//  clr           in   1           clear all membranes; accepted only in IDLE
//  spk_in        in   1024        input spikes, sampled on the cycle start is accepted
//  cfg_thresh    in   V_W         firing threshold, sampled on the cycle start is accepted
//  cfg_leak      in   3           leak shift (0 = no leak), sampled on the cycle start is accepted
//  acc_spk_out   out  1024        latched spikes driven to the accumulator spike input
//  w_rd_en       out  1           weight-row read strobe
//  w_addr        out  clog2(N)    weight row index = neuron index
//  acc_u_in      in   8           accumulator count, 0..255 saturated
//  busy          out  1           high from the cycle after start is accepted until done
//  done          out  1           1-cycle pulse, timestep complete
//  spk_out       out  NUM_NEURONS output spikes, stable from done until next accepted start
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, w_rd_en=0, w_addr=0, spk_out=0, acc_spk_out=0, all v[n]=0.
//  FSM: IDLE -> FETCH -> WAIT -> INTEGRATE -> (FETCH | DONE) -> IDLE.
//  IDLE: clr=1 zeroes all v[n]; clr wins over start in the same cycle (start dropped).
//   start=1 latches spk_in, cfg_thresh and cfg_leak, clears spk_out, sets n=0, goes to FETCH.
//  FETCH (1 cycle): w_rd_en=1, w_addr=n. Next state is WAIT if MEM_LATENCY>1, else INTEGRATE.
//  WAIT: MEM_LATENCY-1 cycles, w_rd_en=0. w_addr holds n.
//  INTEGRATE (1 cycle): samples acc_u_in, which is valid exactly MEM_LATENCY cycles after FETCH.
//   leak = (cfg_leak==0) ? 0 : v[n]>>cfg_leak
//   sum = v[n] - leak + acc_u_in, computed in V_W+1 bits, saturating to 2^V_W-1.
//   If sum >= cfg_thresh: spk_out[n]=1 and v[n]=0. Otherwise v[n]=sum.
//   cfg_thresh==0 therefore fires every neuron every timestep.
//   Leaves for FETCH with n+1 if n<NUM_NEURONS-1, otherwise for DONE.
//  DONE (1 cycle): done=1, busy=0. Next state IDLE.
//   A start in the DONE cycle is ignored; the earliest re-start is the next IDLE cycle.
//  Latency: start accepted at cycle 0 -> done at cycle NUM_NEURONS*(MEM_LATENCY+1)+1.
//  start and clr are ignored while busy. v[] persists across timesteps until clr or rst.
//  acc_spk_out holds its latched value until the next accepted start.
//  rst mid-timestep: abort immediately to the reset values above; no done pulse.
// STRUCTURE
//  snn_pkg: state encoding (IDLE/FETCH/WAIT/INTEGRATE/DONE), ACC_W=8, SPK_W=1024, LEAK_W=3.
//  Sub-module lif_update (combinational): in v, u, thresh, leak; out v_next, fire.
//   Instantiated once and shared by all neurons.
//  Top level holds the FSM, neuron counter, wait counter and the v[] register array.
// TESTING
//  1 N=4, L=1, thresh=10, leak=0, acc_u_in=3 every row, 4 starts
//    -> v=3,6,9 with no spikes; 4th timestep all spk_out=1 and v=0; done at cycle 9 of each.
//  2 L=3, count cycles from start to done
//    -> done at cycle 4*4+1=17; w_rd_en high exactly 4 cycles, w_addr 0..3 in order.
//  3 v[0]=4000, acc_u_in=255, thresh=4095 -> sum saturates to 4095 and fires, v[0]=0.
//    Separately, leak=1 with v=100, u=0 -> v=50.
//  4 start while busy and clr while busy -> both ignored, v unchanged.
//    clr+start in IDLE -> v all 0, no timestep, busy stays 0.
//  5 rst asserted in INTEGRATE of neuron 2 -> next cycle busy=0, w_rd_en=0, spk_out=0, v=0, no done.
//  6 spk_in changed while busy -> acc_spk_out unchanged.
//    spk_out from timestep k held until start of k+1, then cleared.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and widths for the spiking-layer scheduler.
package snn_pkg;
  localparam int ACC_W  = 8;
  localparam int SPK_W  = 1024;
  localparam int LEAK_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_INTEG,
    S_DONE
  } state_e;
endpackage

// File: rtl/layer_scheduler_lif_update.sv
// Combinational leaky integrate-and-fire step for one neuron, shared by all neurons.
module lif_update
  import snn_pkg::*;
#(
  parameter int V_W = 12
) (
  input  logic [V_W-1:0]    v_i,
  input  logic [ACC_W-1:0]  u_i,
  input  logic [V_W-1:0]    thresh_i,
  input  logic [LEAK_W-1:0] leak_i,
  output logic [V_W-1:0]    v_next_o,
  output logic              fire_o
);

  function automatic logic [V_W-1:0] sat_v(input logic [V_W:0] s);
    return s[V_W] ? {V_W{1'b1}} : s[V_W-1:0];
  endfunction

  logic [V_W-1:0] leak_amt;
  logic [V_W:0]   sum;
  logic [V_W-1:0] sum_sat;

  // v - (v >> k) never underflows, so only the upper end needs saturating
  always_comb begin
    leak_amt = (leak_i == '0) ? '0 : (v_i >> leak_i);
    sum      = {1'b0, v_i} - {1'b0, leak_amt} + {{(V_W + 1 - ACC_W){1'b0}}, u_i};
    sum_sat  = sat_v(sum);
    fire_o   = (sum_sat >= thresh_i);
    v_next_o = fire_o ? '0 : sum_sat;
  end

endmodule

// File: rtl/layer_scheduler.sv
// Time-multiplexes one synapse accumulator across NUM_NEURONS LIF neurons per timestep.
module layer_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 32,
  parameter int MEM_LATENCY = 1,
  parameter int V_W         = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clr,
  input  logic [SPK_W-1:0]               spk_in,
  input  logic [V_W-1:0]                 cfg_thresh,
  input  logic [LEAK_W-1:0]              cfg_leak,
  output logic [SPK_W-1:0]               acc_spk_out,
  output logic                           w_rd_en,
  output logic [$clog2(NUM_NEURONS)-1:0] w_addr,
  input  logic [ACC_W-1:0]               acc_u_in,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_NEURONS-1:0]         spk_out
);

  localparam int NW        = $clog2(NUM_NEURONS);
  localparam int WCNT_W    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam int WAIT_INIT = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;

  state_e             state_q;
  logic [NW-1:0]      n_q;
  logic [WCNT_W-1:0]  wait_q;
  logic [V_W-1:0]     v_q [NUM_NEURONS];
  logic [V_W-1:0]     thresh_q;
  logic [LEAK_W-1:0]  leak_q;
  logic [SPK_W-1:0]   acc_spk_q;
  logic [NUM_NEURONS-1:0] spk_out_q;
  logic               busy_q, done_q, w_rd_en_q;
  logic [NW-1:0]      w_addr_q;

  logic [V_W-1:0]     lif_v;
  logic               lif_fire;

  lif_update #(.V_W(V_W)) u_lif (
    .v_i      (v_q[n_q]),
    .u_i      (acc_u_in),
    .thresh_i (thresh_q),
    .leak_i   (leak_q),
    .v_next_o (lif_v),
    .fire_o   (lif_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_rd_en_q <= 1'b0;
      w_addr_q  <= '0;
      spk_out_q <= '0;
      acc_spk_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= '0;
          end else if (start) begin
            acc_spk_q <= spk_in;
            thresh_q  <= cfg_thresh;
            leak_q    <= cfg_leak;
            spk_out_q <= '0;
            n_q       <= '0;
            busy_q    <= 1'b1;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= '0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          w_rd_en_q <= 1'b0;
          if (MEM_LATENCY > 1) begin
            wait_q  <= WCNT_W'(WAIT_INIT);
            state_q <= S_WAIT;
          end else begin
            state_q <= S_INTEG;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) state_q <= S_INTEG;
          else              wait_q  <= wait_q - WCNT_W'(1);
        end
        S_INTEG: begin
          v_q[n_q]       <= lif_v;
          spk_out_q[n_q] <= lif_fire;
          if (n_q == NW'(NUM_NEURONS - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            n_q       <= n_q + NW'(1);
            w_addr_q  <= n_q + NW'(1);
            w_rd_en_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign acc_spk_out = acc_spk_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_addr      = w_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spk_out     = spk_out_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
module tb_layer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 1: N=4, L=1
  logic          start1 = 1'b0, clr1 = 1'b0;
  logic [1023:0] spk_in1 = '0;
  logic [11:0]   th1 = '0;
  logic [2:0]    lk1 = '0;
  logic [1023:0] acc_spk1;
  logic          w_rd_en1, busy1, done1;
  logic [1:0]    w_addr1;
  logic [7:0]    acc_u1;
  logic [3:0]    spk_out1;
  logic [7:0]    u_cur1 = '0;
  logic          q1 = 1'b0;

  // instance 2: N=4, L=3
  logic          start2 = 1'b0, clr2 = 1'b0;
  logic [1023:0] spk_in2 = '0;
  logic [11:0]   th2 = '0;
  logic [2:0]    lk2 = '0;
  logic [1023:0] acc_spk2;
  logic          w_rd_en2, busy2, done2;
  logic [1:0]    w_addr2;
  logic [7:0]    acc_u2;
  logic [3:0]    spk_out2;
  logic [2:0]    p0 = '0, p1 = '0, p2 = '0;
  logic [7:0]    tab2 [4] = '{8'd3, 8'd5, 8'd7, 8'd9};

  layer_scheduler #(.NUM_NEURONS(4), .MEM_LATENCY(1), .V_W(12)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .clr(clr1), .spk_in(spk_in1),
    .cfg_thresh(th1), .cfg_leak(lk1), .acc_spk_out(acc_spk1), .w_rd_en(w_rd_en1),
    .w_addr(w_addr1), .acc_u_in(acc_u1), .busy(busy1), .done(done1), .spk_out(spk_out1)
  );

  layer_scheduler #(.NUM_NEURONS(4), .MEM_LATENCY(3), .V_W(12)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .clr(clr2), .spk_in(spk_in2),
    .cfg_thresh(th2), .cfg_leak(lk2), .acc_spk_out(acc_spk2), .w_rd_en(w_rd_en2),
    .w_addr(w_addr2), .acc_u_in(acc_u2), .busy(busy2), .done(done2), .spk_out(spk_out2)
  );

  // weight-memory models: data valid exactly L cycles after the read strobe, 0 otherwise
  always @(posedge clk) begin
    q1 <= w_rd_en1;
    p0 <= {w_rd_en2, w_addr2};
    p1 <= p0;
    p2 <= p1;
  end
  assign acc_u1 = q1 ? u_cur1 : 8'd0;
  assign acc_u2 = p2[2] ? tab2[p2[1:0]] : 8'd0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]  exp_q [$];
  logic [11:0] v_m1 [4] = '{default: '0};
  logic [11:0] v_m2 [4] = '{default: '0};
  logic [3:0]  last1 = '0;
  logic [3:0]  last2 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_step(input logic [11:0] v, input int u,
                                         input logic [11:0] th, input int lk, output bit f);
    int s;
    s = int'(v);
    if (lk != 0) s = s - (s >> lk);
    s = s + u;
    if (s > 4095) s = 4095;
    f = (s >= int'(th));
    return f ? 12'd0 : 12'(s);
  endfunction

  function automatic logic [1023:0] rnd_spk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk_v1(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, 64'(dut1.v_q[i]), 64'(v_m1[i]));
  endtask

  task automatic run1(input logic [1023:0] spk, input logic [11:0] th, input logic [2:0] lk,
                      input logic [7:0] u, input bit inject);
    logic [3:0] e;
    bit f, seen;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      v_m1[i] = m_step(v_m1[i], int'(u), th, int'(lk), f);
      e[i] = f;
    end
    @(negedge clk);
    chk("spk_hold", 64'(spk_out1), 64'(last1));
    start1 = 1'b1; spk_in1 = spk; th1 = th; lk1 = lk; u_cur1 = u;
    exp_q.push_back(e);
    cyc = 0; seen = 0;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start1 = 1'b0;
        chk("spk_clr", 64'(spk_out1), 64'd0);
        chk("busy_hi", 64'(busy1), 64'd1);
      end
      if (cyc == 3) spk_in1 = ~spk;
      if (inject && cyc == 4) begin start1 = 1'b1; clr1 = 1'b1; end
      if (inject && cyc == 5) begin start1 = 1'b0; clr1 = 1'b0; end
      if (done1) seen = 1;
    end
    chk("lat1", 64'(cyc), 64'd9);
    chk("busy_at_done", 64'(busy1), 64'd0);
    e = exp_q.pop_front();
    chk("spk_out1", 64'(spk_out1), 64'(e));
    last1 = e;
    chk("acc_spk_eq", 64'(acc_spk1 == spk), 64'd1);
    chk("acc_spk_lo", acc_spk1[63:0], spk[63:0]);
    chk_v1("v1");
    @(negedge clk);
    chk("idle_done", 64'(done1), 64'd0);
    chk("idle_busy", 64'(busy1), 64'd0);
  endtask

  task automatic run2(input logic [11:0] th);
    logic [3:0] e;
    bit f, seen;
    int cyc, rd;
    for (int i = 0; i < 4; i++) begin
      v_m2[i] = m_step(v_m2[i], int'(tab2[i]), th, 0, f);
      e[i] = f;
    end
    @(negedge clk);
    chk("spk_hold2", 64'(spk_out2), 64'(last2));
    start2 = 1'b1; spk_in2 = rnd_spk(); th2 = th; lk2 = 3'd0;
    exp_q.push_back(e);
    cyc = 0; seen = 0; rd = 0;
    while (cyc < 60 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start2 = 1'b0;
      if (w_rd_en2) begin
        chk("w_addr2", 64'(w_addr2), 64'(rd));
        rd++;
      end
      if (done2) seen = 1;
    end
    chk("lat2", 64'(cyc), 64'd17);
    chk("rd_cnt2", 64'(rd), 64'd4);
    e = exp_q.pop_front();
    chk("spk_out2", 64'(spk_out2), 64'(e));
    last2 = e;
  endtask

  task automatic clr_start_idle();
    @(negedge clk);
    clr1 = 1'b1; start1 = 1'b1; spk_in1 = rnd_spk();
    @(negedge clk);
    clr1 = 1'b0; start1 = 1'b0;
    chk("cs_busy", 64'(busy1), 64'd0);
    for (int i = 0; i < 4; i++) v_m1[i] = '0;
    @(negedge clk);
    chk("cs_busy2", 64'(busy1), 64'd0);
    chk("cs_done", 64'(done1), 64'd0);
    chk("cs_rd", 64'(w_rd_en1), 64'd0);
    chk_v1("cs_v");
  endtask

  task automatic abort_run();
    int dn;
    @(negedge clk);
    start1 = 1'b1; spk_in1 = rnd_spk(); th1 = 12'd0; lk1 = 3'd0; u_cur1 = 8'd1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
    end
    chk("ab_busy_pre", 64'(busy1), 64'd1);
    chk("ab_rd_pre", 64'(w_rd_en1), 64'd0);
    chk("ab_spk_pre", 64'(spk_out1[1:0]), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin v_m1[i] = '0; v_m2[i] = '0; end
    last1 = '0; last2 = '0;
    chk("ab_busy", 64'(busy1), 64'd0);
    chk("ab_rd", 64'(w_rd_en1), 64'd0);
    chk("ab_spk", 64'(spk_out1), 64'd0);
    chk("ab_done", 64'(done1), 64'd0);
    chk("ab_acc", 64'(acc_spk1 == '0), 64'd1);
    chk_v1("ab_v");
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1) dn++;
    end
    chk("ab_no_done", 64'(dn), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_rd", 64'(w_rd_en1), 64'd0);
    chk("rst_addr", 64'(w_addr1), 64'd0);
    chk("rst_spk", 64'(spk_out1), 64'd0);
    chk("rst_acc", 64'(acc_spk1 == '0), 64'd1);
    chk_v1("rst_v");
    rst = 1'b0;

    // accumulate 3 per timestep against threshold 10: fires on the 4th
    for (int k = 0; k < 4; k++) run1(rnd_spk(), 12'd10, 3'd0, 8'd3, 1'b0);
    // start and clr while busy must be ignored
    run1(rnd_spk(), 12'd10, 3'd0, 8'd3, 1'b1);
    clr_start_idle();

    // ramp to 4000, then overflow saturates at 4095 and fires at thresh 4095
    for (int k = 0; k < 15; k++) run1(rnd_spk(), 12'd4095, 3'd0, 8'd255, 1'b0);
    run1(rnd_spk(), 12'd4095, 3'd0, 8'd175, 1'b0);
    run1(rnd_spk(), 12'd4095, 3'd0, 8'd255, 1'b0);

    // leak: 100 >> 1 leaves 50; zero threshold always fires
    clr_start_idle();
    run1(rnd_spk(), 12'd4095, 3'd0, 8'd100, 1'b0);
    run1(rnd_spk(), 12'd4095, 3'd1, 8'd0, 1'b0);
    run1(rnd_spk(), 12'd0, 3'd0, 8'd0, 1'b0);

    // longer memory latency instance
    run2(12'd8);
    run2(12'd8);

    abort_run();
    run1(rnd_spk(), 12'd10, 3'd0, 8'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
